// File: rtl/sargantana_icache_refill_ctrl.sv
// Instruction-cache miss/refill controller: takes one miss at a time, picks a victim way,
// fetches the line with a single memory beat and writes it into the tag/data arrays.
module sargantana_icache_refill_ctrl #(
  parameter int P_NWAYS  = 4,
  parameter int P_WDEPTH = 64,
  parameter int P_TAG_W  = 20,
  parameter int P_LINE_W = 128,
  localparam int P_WAY_W = $clog2(P_NWAYS),
  localparam int P_SET_W = $clog2(P_WDEPTH)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       miss_i,
  input  logic [P_SET_W-1:0]         miss_set_i,
  input  logic [P_TAG_W-1:0]         miss_tag_i,
  output logic                       miss_ready_o,
  output logic [P_SET_W-1:0]         lru_addr_o,
  input  logic [P_WAY_W-1:0]         lru_way_i,
  input  logic [P_NWAYS-1:0]         way_valid_bits_i,
  output logic                       mem_req_valid_o,
  input  logic                       mem_req_ready_i,
  output logic [P_TAG_W+P_SET_W-1:0] mem_req_addr_o,
  input  logic                       mem_rsp_valid_i,
  input  logic [P_LINE_W-1:0]        mem_rsp_data_i,
  input  logic                       mem_rsp_error_i,
  output logic                       wr_en_o,
  output logic [P_SET_W-1:0]         wr_set_o,
  output logic [P_WAY_W-1:0]         wr_way_o,
  output logic [P_TAG_W-1:0]         wr_tag_o,
  output logic [P_LINE_W-1:0]        wr_data_o,
  output logic                       replace_o,
  output logic [P_WAY_W-1:0]         rep_way_o,
  output logic [P_SET_W-1:0]         rep_set_o,
  output logic                       refill_done_o,
  output logic                       refill_err_o,
  output logic                       busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE} state_e;

  state_e                state_q;
  logic [P_SET_W-1:0]    set_q;
  logic [P_TAG_W-1:0]    tag_q;
  logic [P_WAY_W-1:0]    way_q;
  logic [P_LINE_W-1:0]   data_q;
  logic                  kill_q;
  logic                  err_q;
  logic [P_WAY_W-1:0]    victim_d;
  logic                  accept;

  // An invalid way always wins over the LRU choice; the lowest-index one is taken.
  function automatic logic [P_WAY_W-1:0] pick_victim(input logic [P_NWAYS-1:0] vld,
                                                     input logic [P_WAY_W-1:0] lru);
    logic [P_WAY_W-1:0] w;
    w = lru;
    for (int i = P_NWAYS-1; i >= 0; i--) begin
      if (!vld[i]) w = P_WAY_W'(i);
    end
    return w;
  endfunction

  assign victim_d     = pick_victim(way_valid_bits_i, lru_way_i);
  assign miss_ready_o = (state_q == S_IDLE) & ~flush_i;
  assign accept       = miss_i & miss_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      set_q   <= '0;
      tag_q   <= '0;
      way_q   <= '0;
      data_q  <= '0;
      kill_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          kill_q <= 1'b0;
          if (accept) begin
            set_q   <= miss_set_i;
            tag_q   <= miss_tag_i;
            way_q   <= victim_d;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          // A flush racing the handshake still lets the request go out; its beat is discarded later.
          if (mem_req_ready_i) begin
            kill_q  <= flush_i;
            state_q <= S_WAIT;
          end else if (flush_i) begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid_i) begin
            data_q <= mem_rsp_data_i;
            kill_q <= 1'b0;
            if (kill_q || flush_i) begin
              state_q <= S_IDLE;
            end else if (mem_rsp_error_i) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_WRITE;
            end
          end else if (flush_i) begin
            kill_q <= 1'b1;
          end
        end
        S_WRITE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign lru_addr_o      = (state_q == S_IDLE) ? miss_set_i : set_q;
  assign mem_req_valid_o = (state_q == S_REQ);
  assign mem_req_addr_o  = {tag_q, set_q};
  assign wr_en_o         = (state_q == S_WRITE) & ~flush_i;
  assign replace_o       = wr_en_o;
  assign refill_done_o   = wr_en_o;
  assign wr_set_o        = set_q;
  assign wr_way_o        = way_q;
  assign wr_tag_o        = tag_q;
  assign wr_data_o       = data_q;
  assign rep_way_o       = way_q;
  assign rep_set_o       = set_q;
  assign refill_err_o    = err_q;
  assign busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_sargantana_icache_refill_ctrl.sv
// Bench for the icache refill controller: directed scenarios plus randomized refills
// checked against a transaction-level model of victim choice, timing and LRU updates.
module tb_sargantana_icache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst, flush, miss;
  logic [5:0]   miss_set;
  logic [19:0]  miss_tag;
  logic         miss_ready;
  logic [5:0]   lru_addr;
  logic [1:0]   lru_way;
  logic [3:0]   way_valid;
  logic         mem_req_valid, mem_req_ready;
  logic [25:0]  mem_req_addr;
  logic         mem_rsp_valid, mem_rsp_error;
  logic [127:0] mem_rsp_data;
  logic         wr_en, replace, refill_done, refill_err, busy;
  logic [5:0]   wr_set, rep_set;
  logic [1:0]   wr_way, rep_way;
  logic [19:0]  wr_tag;
  logic [127:0] wr_data;

  int checks = 0;
  int errors = 0;
  int n_wr = 0, n_rep = 0, n_done = 0, n_err = 0;
  int exp_wr = 0, exp_errs = 0;
  logic [1:0] mon_last [64];
  logic [1:0] exp_last [64];

  sargantana_icache_refill_ctrl dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .miss_i(miss),
    .miss_set_i(miss_set), .miss_tag_i(miss_tag), .miss_ready_o(miss_ready),
    .lru_addr_o(lru_addr), .lru_way_i(lru_way), .way_valid_bits_i(way_valid),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_req_addr_o(mem_req_addr), .mem_rsp_valid_i(mem_rsp_valid),
    .mem_rsp_data_i(mem_rsp_data), .mem_rsp_error_i(mem_rsp_error),
    .wr_en_o(wr_en), .wr_set_o(wr_set), .wr_way_o(wr_way), .wr_tag_o(wr_tag),
    .wr_data_o(wr_data), .replace_o(replace), .rep_way_o(rep_way), .rep_set_o(rep_set),
    .refill_done_o(refill_done), .refill_err_o(refill_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Observed LRU-side effects: pulse counts and last victim reported per set.
  always @(negedge clk) begin
    if (wr_en) n_wr++;
    if (replace) begin
      n_rep++;
      mon_last[rep_set] = rep_way;
    end
    if (refill_done) n_done++;
    if (refill_err) n_err++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] ref_victim(input logic [3:0] v, input logic [1:0] lru);
    for (int i = 0; i < 4; i++) if (v[i] == 1'b0) return 2'(i);
    return lru;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs;
    miss = 1'b0; flush = 1'b0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_error = 1'b0;
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    quiet_inputs();
    miss_set = 6'($urandom); miss_tag = 20'($urandom);
    way_valid = 4'($urandom); lru_way = 2'($urandom); mem_rsp_data = rand_line();
    for (int i = 0; i < 64; i++) begin mon_last[i] = 2'd0; exp_last[i] = 2'd0; end
    repeat (2) step();
    #1;
    checks++;
    if ({miss_ready, busy, mem_req_valid, wr_en, replace, refill_done, refill_err} !== 7'b1000000)
      begin errors++; $display("FAIL reset_ctrl: got %b expected 1000000",
        {miss_ready, busy, mem_req_valid, wr_en, replace, refill_done, refill_err}); end
    checks++;
    if (lru_addr !== miss_set)
      begin errors++; $display("FAIL reset_lru_addr: got %h expected %h", lru_addr, miss_set); end
    checks++;
    if ({mem_req_addr, wr_set, wr_way, wr_tag, rep_way, rep_set, wr_data} !== '0)
      begin errors++; $display("FAIL reset_regs: addr=%h set=%h way=%h tag=%h data=%h expected all zero",
        mem_req_addr, wr_set, wr_way, wr_tag, wr_data); end
    rst = 1'b0;
    step();
  endtask

  // One complete miss: accept, request (rdly stall cycles), wait (wdly idle cycles), then write or error.
  task automatic run_refill(input logic [5:0] s, input logic [19:0] t, input logic [3:0] v,
                            input logic [1:0] l, input logic [127:0] d, input int rdly,
                            input int wdly, input bit err, input bit fl_wr);
    logic [1:0] ew;
    logic [2:0] exp3;
    ew = ref_victim(v, l);
    flush = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    miss = 1'b1; miss_set = s; miss_tag = t; way_valid = v; lru_way = l;
    #1;
    checks++;
    if (miss_ready !== 1'b1 || lru_addr !== s)
      begin errors++; $display("FAIL accept: ready=%b lru_addr=%h expected 1 %h", miss_ready, lru_addr, s); end
    step();
    miss = 1'b0;
    for (int r = 0; r <= rdly; r++) begin
      miss_set = 6'($urandom); way_valid = 4'($urandom); lru_way = 2'($urandom);
      mem_req_ready = (r == rdly);
      mem_rsp_valid = 1'($urandom); mem_rsp_error = 1'($urandom); mem_rsp_data = rand_line();
      #1;
      checks++;
      if ({mem_req_valid, busy, miss_ready} !== 3'b110 || mem_req_addr !== {t, s} || lru_addr !== s)
        begin errors++; $display("FAIL req_cycle%0d: vld/busy/rdy=%b addr=%h lru_addr=%h expected 110 %h %h",
          r, {mem_req_valid, busy, miss_ready}, mem_req_addr, lru_addr, {t, s}, s); end
      step();
    end
    mem_req_ready = 1'b0;
    for (int w = 0; w <= wdly; w++) begin
      mem_rsp_valid = (w == wdly);
      mem_rsp_data  = (w == wdly) ? d : rand_line();
      mem_rsp_error = (w == wdly) ? err : 1'($urandom);
      #1;
      checks++;
      if ({mem_req_valid, busy, miss_ready, wr_en} !== 4'b0100)
        begin errors++; $display("FAIL wait_cycle%0d: got %b expected 0100",
          w, {mem_req_valid, busy, miss_ready, wr_en}); end
      step();
    end
    mem_rsp_valid = 1'b0; mem_rsp_error = 1'b0; mem_rsp_data = rand_line();
    if (!err) begin
      flush = fl_wr;
      exp3 = fl_wr ? 3'b000 : 3'b111;
      #1;
      checks++;
      if ({wr_en, replace, refill_done} !== exp3 || refill_err !== 1'b0)
        begin errors++; $display("FAIL write_strobes: got %b err=%b expected %b err=0",
          {wr_en, replace, refill_done}, refill_err, exp3); end
      checks++;
      if (wr_set !== s || wr_way !== ew || wr_tag !== t || wr_data !== d || rep_set !== s || rep_way !== ew)
        begin errors++; $display("FAIL write_fields: set=%h way=%h tag=%h rset=%h rway=%h expected %h %h %h", wr_set,
          wr_way, wr_tag, rep_set, rep_way, s, ew, t); end
      if (!fl_wr) begin exp_wr++; exp_last[s] = ew; end
      step();
      flush = 1'b0;
    end else begin
      #1;
      checks++;
      if ({miss_ready, busy, wr_en, replace, refill_done, refill_err} !== 6'b100001)
        begin errors++; $display("FAIL err_pulse: got %b expected 100001",
          {miss_ready, busy, wr_en, replace, refill_done, refill_err}); end
      exp_errs++;
      step();
    end
    #1;
    checks++;
    if ({miss_ready, busy, wr_en, replace, refill_done, refill_err} !== 6'b100000)
      begin errors++; $display("FAIL back_to_idle: got %b expected 100000",
        {miss_ready, busy, wr_en, replace, refill_done, refill_err}); end
  endtask

  task automatic test_plan_example;
    run_refill(6'd5, 20'h12345, 4'b1011, 2'($urandom), rand_line(), 0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_all_valid;
    run_refill(6'($urandom), 20'($urandom), 4'b1111, 2'd3, rand_line(), 0, 1, 1'b0, 1'b0);
    run_refill(6'($urandom), 20'($urandom), 4'b1111, 2'd1, rand_line(), 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ready_stall;
    run_refill(6'($urandom), 20'($urandom), 4'($urandom), 2'($urandom), rand_line(), 6, 1, 1'b0, 1'b0);
  endtask

  task automatic test_error;
    run_refill(6'($urandom), 20'($urandom), 4'($urandom), 2'($urandom), rand_line(), 1, 2, 1'b1, 1'b0);
  endtask

  task automatic test_flush_write;
    run_refill(6'($urandom), 20'($urandom), 4'($urandom), 2'($urandom), rand_line(), 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_flush_req;
    miss = 1'b1; miss_set = 6'($urandom); miss_tag = 20'($urandom); way_valid = 4'($urandom);
    step();
    miss = 1'b0; flush = 1'b1; mem_req_ready = 1'b0;
    #1;
    checks++;
    if ({mem_req_valid, miss_ready} !== 2'b10)
      begin errors++; $display("FAIL flush_req_cycle: got %b expected 10", {mem_req_valid, miss_ready}); end
    step();
    flush = 1'b0;
    #1;
    checks++;
    if ({mem_req_valid, busy, miss_ready} !== 3'b001)
      begin errors++; $display("FAIL flush_req_idle: got %b expected 001", {mem_req_valid, busy, miss_ready}); end
    miss = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (miss_ready !== 1'b0)
      begin errors++; $display("FAIL flush_blocks_ready: got %b expected 0", miss_ready); end
    step();
    miss = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if ({busy, mem_req_valid} !== 2'b00)
      begin errors++; $display("FAIL flush_no_accept: got %b expected 00", {busy, mem_req_valid}); end
  endtask

  task automatic test_flush_wait;
    miss = 1'b1; miss_set = 6'($urandom); miss_tag = 20'($urandom); way_valid = 4'($urandom);
    step();
    miss = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      mem_rsp_valid = (k == 3); mem_rsp_error = 1'b0; mem_rsp_data = rand_line();
      #1;
      checks++;
      if ({busy, miss_ready} !== 2'b10)
        begin errors++; $display("FAIL flush_wait_hold%0d: got %b expected 10", k, {busy, miss_ready}); end
      step();
    end
    mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if ({miss_ready, busy, wr_en, replace, refill_done, refill_err} !== 6'b100000)
      begin errors++; $display("FAIL flush_wait_drop: got %b expected 100000",
        {miss_ready, busy, wr_en, replace, refill_done, refill_err}); end
  endtask

  task automatic test_flush_with_ready;
    miss = 1'b1; miss_set = 6'($urandom); miss_tag = 20'($urandom); way_valid = 4'($urandom);
    step();
    miss = 1'b0; mem_req_ready = 1'b1; flush = 1'b1;
    step();
    mem_req_ready = 1'b0; flush = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_error = 1'b0; mem_rsp_data = rand_line();
    #1;
    checks++;
    if ({busy, mem_req_valid} !== 2'b10)
      begin errors++; $display("FAIL flush_ready_wait: got %b expected 10", {busy, mem_req_valid}); end
    step();
    mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if ({miss_ready, busy, wr_en, replace, refill_done, refill_err} !== 6'b100000)
      begin errors++; $display("FAIL flush_ready_drop: got %b expected 100000",
        {miss_ready, busy, wr_en, replace, refill_done, refill_err}); end
  endtask

  task automatic test_reset_mid;
    miss = 1'b1; miss_set = 6'($urandom); miss_tag = 20'($urandom) | 20'h1; way_valid = 4'($urandom);
    step();
    miss = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1)
      begin errors++; $display("FAIL reset_mid_pre: busy=%b expected 1", busy); end
    rst = 1'b1;
    #1;
    checks++;
    if ({miss_ready, busy, mem_req_valid, wr_en, replace, refill_done, refill_err} !== 7'b1000000 ||
        mem_req_addr !== '0 || lru_addr !== miss_set)
      begin errors++; $display("FAIL reset_mid_async: ctrl=%b addr=%h lru_addr=%h expected 1000000 0 %h",
        {miss_ready, busy, mem_req_valid, wr_en, replace, refill_done, refill_err},
        mem_req_addr, lru_addr, miss_set); end
    step();
    rst = 1'b0;
    step();
    mem_rsp_valid = 1'b1; mem_rsp_data = rand_line();
    step();
    mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if ({miss_ready, busy, wr_en, replace, refill_done, refill_err} !== 6'b100000)
      begin errors++; $display("FAIL late_beat_ignored: got %b expected 100000",
        {miss_ready, busy, wr_en, replace, refill_done, refill_err}); end
  endtask

  // miss_i held high throughout: the second miss must wait until the first has been written.
  task automatic test_back_to_back;
    logic [5:0] s1, s2; logic [19:0] t1, t2; logic [3:0] v1, v2; logic [127:0] d1, d2;
    s1 = 6'($urandom); t1 = 20'($urandom); v1 = 4'($urandom); d1 = rand_line();
    s2 = ~s1; t2 = 20'($urandom); v2 = 4'b1111; d2 = rand_line();
    miss = 1'b1; miss_set = s1; miss_tag = t1; way_valid = v1; lru_way = 2'd2;
    step();
    miss_set = s2; miss_tag = t2; way_valid = v2; lru_way = 2'd0; mem_req_ready = 1'b1;
    #1;
    checks++;
    if (miss_ready !== 1'b0 || mem_req_addr !== {t1, s1})
      begin errors++; $display("FAIL b2b_first_req: ready=%b addr=%h expected 0 %h", miss_ready, mem_req_addr, {t1, s1}); end
    step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = d1;
    step();
    mem_rsp_valid = 1'b0; mem_rsp_data = rand_line();
    #1;
    checks++;
    if (wr_en !== 1'b1 || miss_ready !== 1'b0 || wr_set !== s1 || wr_way !== ref_victim(v1, 2'd2) || wr_data !== d1)
      begin errors++; $display("FAIL b2b_first_write: en=%b rdy=%b set=%h way=%h expected 1 0 %h %h",
        wr_en, miss_ready, wr_set, wr_way, s1, ref_victim(v1, 2'd2)); end
    exp_wr++; exp_last[s1] = ref_victim(v1, 2'd2);
    step();
    #1;
    checks++;
    if (miss_ready !== 1'b1 || lru_addr !== s2)
      begin errors++; $display("FAIL b2b_second_accept: rdy=%b lru_addr=%h expected 1 %h", miss_ready, lru_addr, s2); end
    step();
    miss = 1'b0; mem_req_ready = 1'b1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== {t2, s2})
      begin errors++; $display("FAIL b2b_second_req: vld=%b addr=%h expected 1 %h", mem_req_valid, mem_req_addr, {t2, s2}); end
    step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = d2;
    step();
    mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if (wr_en !== 1'b1 || wr_set !== s2 || wr_way !== 2'd0 || wr_tag !== t2 || wr_data !== d2)
      begin errors++; $display("FAIL b2b_second_write: en=%b set=%h way=%h tag=%h expected 1 %h 0 %h",
        wr_en, wr_set, wr_way, wr_tag, s2, t2); end
    exp_wr++; exp_last[s2] = 2'd0;
    step();
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      bit e, f;
      e = ($urandom_range(0, 4) == 0);
      f = !e && ($urandom_range(0, 5) == 0);
      run_refill(6'($urandom), 20'($urandom), 4'($urandom), 2'($urandom), rand_line(),
                 $urandom_range(0, 3), $urandom_range(0, 4), e, f);
    end
  endtask

  task automatic test_lru_side_effects;
    #1;
    checks++;
    if (n_wr !== exp_wr || n_rep !== exp_wr || n_done !== exp_wr || n_err !== exp_errs)
      begin errors++; $display("FAIL pulse_counts: wr=%0d rep=%0d done=%0d err=%0d expected %0d %0d %0d %0d",
        n_wr, n_rep, n_done, n_err, exp_wr, exp_wr, exp_wr, exp_errs); end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (mon_last[i] !== exp_last[i])
        begin errors++; $display("FAIL lru_set%0d: got way %0d expected %0d", i, mon_last[i], exp_last[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_plan_example();
    test_all_valid();
    test_ready_stall();
    test_error();
    test_flush_write();
    test_flush_req();
    test_flush_wait();
    test_flush_with_ready();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_lru_side_effects();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sargantana_icache_refill_ctrl.md
Name: sargantana_icache_refill_ctrl

Overview:
- Instruction-cache miss/refill controller, sitting directly upstream of the LRU unit and the tag/data arrays.
- Accepts one miss at a time, selects a victim way, fetches the line from memory and writes it into the arrays.
- Issues the one-cycle replace pulse, victim way and set that the LRU unit consumes.
- Handles flush and memory error without corrupting array or LRU state.

Parameters:
- P_NWAYS, 4, number of ways (power of 2, ≥2); P_WAY_W = $clog2(P_NWAYS).
- P_WDEPTH, 64, number of sets (power of 2); P_SET_W = $clog2(P_WDEPTH).
- P_TAG_W, 20, tag width.
- P_LINE_W, 128, cache line width in bits, returned in one memory beat.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  cache flush; aborts or kills the refill in progress.
- miss_i  in  1  miss request valid.
- miss_set_i  in  P_SET_W  set index of the miss.
- miss_tag_i  in  P_TAG_W  tag of the miss.
- miss_ready_o  out  1  controller can accept a miss.
- lru_addr_o  out  P_SET_W  set index driven to the LRU unit's lookup address.
- lru_way_i  in  P_WAY_W  LRU way of the set on lru_addr_o, combinational from the LRU unit.
- way_valid_bits_i  in  P_NWAYS  valid bits of set miss_set_i, same cycle.
- mem_req_valid_o  out  1  line fetch request valid.
- mem_req_ready_i  in  1  memory accepts the request.
- mem_req_addr_o  out  P_TAG_W+P_SET_W  line address {tag, set}.
- mem_rsp_valid_i  in  1  response beat valid; always accepted.
- mem_rsp_data_i  in  P_LINE_W  line data.
- mem_rsp_error_i  in  1  response carries a bus error.
- wr_en_o  out  1  array write strobe.
- wr_set_o  out  P_SET_W  array write set.
- wr_way_o  out  P_WAY_W  array write way.
- wr_tag_o  out  P_TAG_W  array write tag.
- wr_data_o  out  P_LINE_W  array write line.
- replace_o  out  1  replace pulse to the LRU unit.
- rep_way_o  out  P_WAY_W  victim way to the LRU unit.
- rep_set_o  out  P_SET_W  victim set to the LRU unit.
- refill_done_o  out  1  one-cycle pulse: refill completed.
- refill_err_o  out  1  one-cycle pulse: refill dropped because of a memory error.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE; all registers zero.
  - All outputs 0 except miss_ready_o = 1.
  - lru_addr_o = miss_set_i.
- FSM states: IDLE, REQ, WAIT, WRITE.
- miss_ready_o = (state == IDLE) & ~flush_i. Accept = miss_i & miss_ready_o.
- IDLE, on accept:
  - Register set and tag.
  - Register the victim way: lowest-index way with way_valid_bits_i == 0; if all ways are valid, lru_way_i.
  - Go to REQ.
- lru_addr_o = miss_set_i in IDLE, registered set otherwise.
- REQ:
  - mem_req_valid_o = 1, mem_req_addr_o = {tag, set}.
  - Valid and addr stay stable until mem_req_ready_i; then go to WAIT.
  - flush_i without ready: go to IDLE, no request issued.
  - flush_i with ready in the same cycle: go to WAIT with kill = 1.
- WAIT:
  - flush_i sets kill.
  - On mem_rsp_valid_i, capture the data:
    - kill set (including flush in the same cycle): drop the line, go to IDLE, no pulses.
    - Otherwise, mem_rsp_error_i = 1: pulse refill_err_o next cycle, go to IDLE.
    - Otherwise: go to WRITE.
- WRITE (exactly 1 cycle):
  - wr_en_o = replace_o = refill_done_o = 1.
  - wr_* and rep_* carry the registered set, way, tag and data.
  - flush_i in this cycle suppresses all three strobes.
  - Then go to IDLE.
- Latency:
  - Accept at cycle 0 → mem_req_valid_o at cycle 1.
  - Response at cycle N → WRITE at N+1 → miss_ready_o high again at N+2 (if no flush).
- No second miss is accepted until the FSM returns to IDLE; no request buffering.
- Response beats arriving in IDLE or REQ are ignored.
- rst_i asserted mid-refill: immediate return to IDLE; all strobes drop asynchronously.
- kill clears on entry to IDLE.

Test Plan:
- Reset, then miss set=5 tag=0x12345 with way_valid=4'b1011 → mem_req_addr_o={0x12345,5} at cycle 1. Response at cycle 4 → cycle 5: wr_en_o=replace_o=refill_done_o=1, wr_way_o=rep_way_o=2, wr_set_o=5. miss_ready_o=1 at cycle 6.
- way_valid=4'b1111, lru_way_i=3 → victim way 3; lru_addr_o equals miss_set_i during the accept cycle.
- mem_req_ready_i held low 6 cycles → mem_req_valid_o and mem_req_addr_o stable throughout; WAIT entered only after ready.
- flush_i in REQ without ready → IDLE next cycle, no request. flush_i in WAIT, response 3 cycles later → no wr_en_o/replace_o; miss_ready_o=1 the cycle after the response.
- Response with mem_rsp_error_i=1 → refill_err_o single pulse; wr_en_o, replace_o and refill_done_o stay 0; LRU state unchanged.
- rst_i asserted in WAIT → all outputs at reset values asynchronously; a late response beat after reset release is ignored.
